// File: rtl/deserializer_pkg.sv
// Shared constants and types for the serial-to-parallel receiver.
// Build macro DESERIALIZER_LAST_EN (see deserializer.sv) enables short-word support.
package deserializer_pkg;

   localparam int DEF_DATA_W  = 16;
   localparam int DEF_MOD_W   = $clog2(DEF_DATA_W);
   localparam int DEF_TIMEOUT = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } deser_state_t;

endpackage

// File: rtl/deserializer_gap_timer.sv
// Counts consecutive idle cycles inside a partial word and strobes when the gap limit is hit.
// TIMEOUT of 0 removes the timer entirely.
module deserializer_gap_timer #(
   parameter int TIMEOUT = 8
) (
   input  logic clk_i,
   input  logic srst_i,
   input  logic active_i,
   input  logic bit_val_i,
   output logic timeout_o
);

   generate
      if (TIMEOUT > 0) begin : g_timer
         localparam int GAP_W = $clog2(TIMEOUT + 1);

         logic [GAP_W-1:0] gap_q;
         logic [GAP_W-1:0] gap_d;
         logic             limit_s;

         assign limit_s = (gap_q == GAP_W'(TIMEOUT - 1));

         // next gap count: any valid bit or leaving the word restarts the count
         always_comb begin
            gap_d = gap_q;
            if (!active_i || bit_val_i) begin
               gap_d = '0;
            end else if (limit_s) begin
               gap_d = '0;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end

         // gap counter register
         always_ff @(posedge clk_i) begin
            if (srst_i) begin
               gap_q <= '0;
            end else begin
               gap_q <= gap_d;
            end
         end

         // the strobe marks the final idle cycle; a valid bit in that cycle cancels it
         assign timeout_o = active_i && !bit_val_i && limit_s;
      end else begin : g_no_timer
         logic unused_s;
         assign unused_s  = ^{clk_i, srst_i, active_i, bit_val_i};
         assign timeout_o = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: rebuilds MSB-first words, pulses valid, drops stalled partial words.
// Optional build macro DESERIALIZER_LAST_EN adds ser_last_i / deser_data_mod_o for short words.
module deserializer
   import deserializer_pkg::*;
#(
   parameter int  DATA_W  = DEF_DATA_W,
   parameter int  TIMEOUT = DEF_TIMEOUT,
   localparam int MOD_W   = $clog2(DATA_W)
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              ser_data_i,
   input  logic              ser_data_val_i,
   output logic [DATA_W-1:0] deser_data_o,
   output logic              deser_data_val_o,
   output logic              busy_o,
   output logic              drop_o
`ifdef DESERIALIZER_LAST_EN
   ,
   input  logic              ser_last_i,
   output logic [MOD_W-1:0]  deser_data_mod_o
`endif
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   deser_state_t      state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-2:0] shift_q, shift_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              val_q, val_d;
   logic              busy_q, busy_d;
   logic              drop_q, drop_d;

   logic [DATA_W-1:0] word_s;
   logic [DATA_W-1:0] aligned_s;
   logic [CNT_W-1:0]  cnt_inc_s;
   logic              last_s;
   logic              complete_s;
   logic              timeout_s;

`ifdef DESERIALIZER_LAST_EN
   logic [MOD_W-1:0]  mod_q, mod_d;
`endif

   deserializer_gap_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_gap_timer (
      .clk_i     (clk_i),
      .srst_i    (srst_i),
      .active_i  (state_q == RECV),
      .bit_val_i (ser_data_val_i),
      .timeout_o (timeout_s)
   );

   // the stored bits plus the incoming one form the candidate word; the final bit never needs a flop
   always_comb begin
      word_s    = {shift_q, ser_data_i};
      cnt_inc_s = cnt_q + CNT_W'(1);
`ifdef DESERIALIZER_LAST_EN
      last_s    = ser_last_i;
      aligned_s = word_s << (CNT_W'(DATA_W) - cnt_inc_s);
`else
      last_s    = 1'b0;
      aligned_s = word_s;
`endif
      complete_s = (cnt_inc_s == CNT_W'(DATA_W)) || last_s;
   end

   // word assembly FSM; a valid bit always takes priority over the gap timeout
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      data_d  = data_q;
      val_d   = 1'b0;
      drop_d  = 1'b0;
`ifdef DESERIALIZER_LAST_EN
      mod_d   = mod_q;
`endif
      case (state_q)
         IDLE, RECV: begin
            if (ser_data_val_i) begin
               if (complete_s) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  shift_d = '0;
                  data_d  = aligned_s;
                  val_d   = 1'b1;
`ifdef DESERIALIZER_LAST_EN
                  mod_d   = (cnt_inc_s == CNT_W'(DATA_W)) ? '0 : cnt_inc_s[MOD_W-1:0];
`endif
               end else begin
                  state_d = RECV;
                  cnt_d   = cnt_inc_s;
                  shift_d = word_s[DATA_W-2:0];
               end
            end else if ((state_q == RECV) && timeout_s) begin
               state_d = IDLE;
               cnt_d   = '0;
               shift_d = '0;
               drop_d  = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            shift_d = '0;
         end
      endcase
      busy_d = (cnt_d != '0);
   end

   // state and output registers
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         val_q   <= 1'b0;
         busy_q  <= 1'b0;
         drop_q  <= 1'b0;
`ifdef DESERIALIZER_LAST_EN
         mod_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         val_q   <= val_d;
         busy_q  <= busy_d;
         drop_q  <= drop_d;
`ifdef DESERIALIZER_LAST_EN
         mod_q   <= mod_d;
`endif
      end
   end

   assign deser_data_o     = data_q;
   assign deser_data_val_o = val_q;
   assign busy_o           = busy_q;
   assign drop_o           = drop_q;
`ifdef DESERIALIZER_LAST_EN
   assign deser_data_mod_o = mod_q;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer: stimulus pushes expected words/drops, a monitor pops and compares.
module tb_deserializer;

   logic        clk_i = 1'b0;
   logic        srst_i = 1'b1;
   logic        ser_data_i = 1'b0;
   logic        ser_data_val_i = 1'b0;
   logic [15:0] deser_data_o;
   logic        deser_data_val_o;
   logic        busy_o;
   logic        drop_o;
`ifdef DESERIALIZER_LAST_EN
   logic        ser_last_i = 1'b0;
   logic [3:0]  deser_data_mod_o;
`endif

   typedef struct {
      bit          is_drop;
      logic [15:0] data;
      logic [3:0]  mod;
   } exp_t;

   exp_t exp_q[$];
   int   pulse_cyc[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   deserializer #(.DATA_W(16), .TIMEOUT(8)) dut (
      .clk_i            (clk_i),
      .srst_i           (srst_i),
      .ser_data_i       (ser_data_i),
      .ser_data_val_i   (ser_data_val_i),
      .deser_data_o     (deser_data_o),
      .deser_data_val_o (deser_data_val_o),
      .busy_o           (busy_o),
      .drop_o           (drop_o)
`ifdef DESERIALIZER_LAST_EN
      ,
      .ser_last_i       (ser_last_i),
      .deser_data_mod_o (deser_data_mod_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // drive one cycle of inputs, return 1 ns after the sampling edge
   task automatic drive(input logic v, input logic d, input logic l);
      ser_data_val_i = v;
      ser_data_i     = d;
`ifdef DESERIALIZER_LAST_EN
      ser_last_i     = l;
`else
      if (l) $display("last flag ignored in this build");
`endif
      @(posedge clk_i);
      #1;
      ser_data_val_i = 1'b0;
      ser_data_i     = 1'b0;
`ifdef DESERIALIZER_LAST_EN
      ser_last_i     = 1'b0;
`endif
   endtask

   task automatic push_exp(input bit is_drop, input logic [15:0] data, input logic [3:0] mod);
      exp_t e;
      e.is_drop = is_drop;
      e.data    = data;
      e.mod     = mod;
      exp_q.push_back(e);
   endtask

   // send a full word MSB first with `gap` idle cycles after each bit; optional mid-word hold check
   task automatic send_word(input logic [15:0] w, input int gap, input bit chk_hold,
                            input logic [15:0] hold);
      for (int i = 15; i >= 0; i--) begin
         if (chk_hold && i == 7) check("data_held", deser_data_o, hold);
         if (i == 0) push_exp(1'b0, w, 4'd0);
         drive(1'b1, w[i], 1'b0);
         if (i != 0) repeat (gap) drive(1'b0, 1'b0, 1'b0);
      end
   endtask

   // monitor: every val or drop pulse must match the head of the scoreboard
   always @(negedge clk_i) begin
      if (deser_data_val_o || drop_o) begin
         if (deser_data_val_o) pulse_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {30'd0, deser_data_val_o, drop_o}, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("pulse_kind", {30'd0, deser_data_val_o, drop_o}, {30'd0, ~e.is_drop, e.is_drop});
            if (!e.is_drop) begin
               check("word_data", deser_data_o, e.data);
`ifdef DESERIALIZER_LAST_EN
               check("word_mod", deser_data_mod_o, e.mod);
`endif
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] pat;
      int          k;

      // reset
      srst_i = 1'b1;
      repeat (3) drive(1'b0, 1'b0, 1'b0);
      check("rst_data", deser_data_o, 16'h0);
      check("rst_val", deser_data_val_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_drop", drop_o, 1'b0);
      srst_i = 1'b0;

      // test 1: F0F0 with busy tracking bit by bit
      pat = 16'hF0F0;
      k = 0;
      for (int i = 15; i >= 0; i--) begin
         check("busy_track", busy_o, (k != 0));
         if (i == 0) push_exp(1'b0, pat, 4'd0);
         drive(1'b1, pat[i], 1'b0);
         k++;
      end
      check("busy_after_word", busy_o, 1'b0);
      drive(1'b0, 1'b0, 1'b0);

      // test 2: A5A5 with two idle cycles between bits
      send_word(16'hA5A5, 2, 1'b0, 16'h0);
      drive(1'b0, 1'b0, 1'b0);

      // test 3: back-to-back words, pulses 16 cycles apart, data held between
      pulse_cyc.delete();
      send_word(16'h1234, 0, 1'b0, 16'h0);
      send_word(16'hFFFF, 0, 1'b1, 16'h1234);
      drive(1'b0, 1'b0, 1'b0);
      check("b2b_count", pulse_cyc.size(), 2);
      check("b2b_spacing", (pulse_cyc.size() >= 2) ? (pulse_cyc[1] - pulse_cyc[0]) : 0, 16);

      // boundary: seven idle cycles then a bit on the eighth cycle is accepted, no drop
      send_word(16'h3C3C, 7, 1'b0, 16'h0);
      drive(1'b0, 1'b0, 1'b0);

      // test 4: five bits then eight idle cycles -> drop, data unchanged
      pat = 16'hB800;
      for (int i = 15; i >= 11; i--) drive(1'b1, pat[i], 1'b0);
      check("busy_partial", busy_o, 1'b1);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) push_exp(1'b1, 16'h0, 4'd0);
         drive(1'b0, 1'b0, 1'b0);
      end
      check("drop_pulse", drop_o, 1'b1);
      check("drop_busy", busy_o, 1'b0);
      check("drop_data_kept", deser_data_o, 16'h3C3C);
      send_word(16'h0F0F, 0, 1'b0, 16'h0);
      drive(1'b0, 1'b0, 1'b0);

      // test 5: soft reset mid-word
      pat = 16'hAAAA;
      for (int i = 15; i >= 9; i--) drive(1'b1, pat[i], 1'b0);
      srst_i = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      srst_i = 1'b0;
      check("srst_data", deser_data_o, 16'h0);
      check("srst_val", deser_data_val_o, 1'b0);
      check("srst_busy", busy_o, 1'b0);
      check("srst_drop", drop_o, 1'b0);
      send_word(16'hC3C3, 0, 1'b0, 16'h0);
      drive(1'b0, 1'b0, 1'b0);

`ifdef DESERIALIZER_LAST_EN
      // test 6: short word ended by last, then a full word
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      push_exp(1'b0, 16'hB000, 4'd4);
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      check("last_mod_held", deser_data_mod_o, 4'd4);
      send_word(16'h8001, 0, 1'b0, 16'h0);
      drive(1'b0, 1'b0, 1'b0);
`endif

      repeat (12) drive(1'b0, 1'b0, 1'b0);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
